// File: rtl/unison_pkg.sv
// Shared serializer state encoding and readout lane width for the unison array readout.
package unison_pkg;

  localparam int unsigned LANE_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/unison_updown_counter.sv
// Signed up/down event accumulator with synchronous frame clear.
// Saturates at the signed limits when UNISON_SAT_EN is defined, otherwise wraps.
module unison_updown_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_master,
  input  logic             rstb,
  input  logic             en,
  input  logic             hit,
  input  logic             up,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt_next_c
);

  logic [CNT_W-1:0] cnt;

`ifdef UNISON_SAT_EN
  localparam logic [CNT_W-1:0] MAX_V = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] MIN_V = {1'b1, {(CNT_W-1){1'b0}}};
`endif

  // Value including this cycle's event; also feeds the snapshot shadow.
  always_comb begin
    cnt_next_c = cnt;
    if (en && hit) begin
`ifdef UNISON_SAT_EN
      if (up && (cnt != MAX_V)) begin
        cnt_next_c = cnt + CNT_W'(1);
      end else if (!up && (cnt != MIN_V)) begin
        cnt_next_c = cnt - CNT_W'(1);
      end
`else
      cnt_next_c = up ? (cnt + CNT_W'(1)) : (cnt - CNT_W'(1));
`endif
    end
  end

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next_c;
    end
  end

endmodule

// File: rtl/unison_array_readout.sv
// Per-channel I/Q event accumulation over fixed frames with 2-bit serial readout of each snapshot.
// Optional build macro UNISON_SAT_EN selects saturating instead of wrapping accumulators.
module unison_array_readout
  import unison_pkg::*;
#(
  parameter int unsigned NUM_CH    = 6,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned FRAME_LEN = 256
) (
  input  logic              clk_master,
  input  logic              rstb,
  input  logic              ud_en,
  input  logic [NUM_CH-1:0] comp_high_I,
  input  logic [NUM_CH-1:0] comp_high_Q,
  input  logic [NUM_CH-1:0] lo_I,
  input  logic [NUM_CH-1:0] lo_Q,
  output logic [LANE_W-1:0] read_out_I,
  output logic [LANE_W-1:0] read_out_Q,
  output logic              frame_sync,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned SR_W   = NUM_CH * CNT_W;
  localparam int unsigned NBEATS = SR_W / LANE_W;
  localparam int unsigned BEAT_W = $clog2(NBEATS + 1);
  localparam int unsigned FC_W   = $clog2(FRAME_LEN);
  localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(FRAME_LEN - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NBEATS);

  logic [FC_W-1:0]   fcnt;
  logic              snapshot_c;
  logic [SR_W-1:0]   acc_next_i;
  logic [SR_W-1:0]   acc_next_q;

  ser_state_e        state, state_nxt;
  logic [BEAT_W-1:0] beat, beat_nxt;
  logic [SR_W-1:0]   shift_i, shift_i_nxt;
  logic [SR_W-1:0]   shift_q, shift_q_nxt;
  logic [LANE_W-1:0] ro_i_nxt, ro_q_nxt;
  logic              sync_nxt, busy_nxt, overrun_nxt;

  assign snapshot_c = ud_en && (fcnt == FC_LAST);

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      fcnt <= '0;
    end else if (ud_en) begin
      fcnt <= snapshot_c ? '0 : (fcnt + FC_W'(1));
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    unison_updown_counter #(.CNT_W(CNT_W)) u_cnt_i (
      .clk_master (clk_master),
      .rstb       (rstb),
      .en         (ud_en),
      .hit        (comp_high_I[ch]),
      .up         (lo_I[ch]),
      .clear      (snapshot_c),
      .cnt_next_c (acc_next_i[ch*CNT_W +: CNT_W])
    );
    unison_updown_counter #(.CNT_W(CNT_W)) u_cnt_q (
      .clk_master (clk_master),
      .rstb       (rstb),
      .en         (ud_en),
      .hit        (comp_high_Q[ch]),
      .up         (lo_Q[ch]),
      .clear      (snapshot_c),
      .cnt_next_c (acc_next_q[ch*CNT_W +: CNT_W])
    );
  end

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      state      <= ST_IDLE;
      beat       <= '0;
      shift_i    <= '0;
      shift_q    <= '0;
      read_out_I <= '0;
      read_out_Q <= '0;
      frame_sync <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      beat       <= beat_nxt;
      shift_i    <= shift_i_nxt;
      shift_q    <= shift_q_nxt;
      read_out_I <= ro_i_nxt;
      read_out_Q <= ro_q_nxt;
      frame_sync <= sync_nxt;
      busy       <= busy_nxt;
      overrun    <= overrun_nxt;
    end
  end

  // Beat 0 goes straight to the lanes on the snapshot edge; the shadow keeps the remainder.
  always_comb begin
    state_nxt   = state;
    beat_nxt    = beat;
    shift_i_nxt = shift_i;
    shift_q_nxt = shift_q;
    ro_i_nxt    = '0;
    ro_q_nxt    = '0;
    sync_nxt    = 1'b0;
    busy_nxt    = busy;
    overrun_nxt = overrun;
    if (snapshot_c) begin
      overrun_nxt = overrun | (state == ST_SHIFT);
      state_nxt   = ST_SHIFT;
      busy_nxt    = 1'b1;
      sync_nxt    = 1'b1;
      ro_i_nxt    = acc_next_i[LANE_W-1:0];
      ro_q_nxt    = acc_next_q[LANE_W-1:0];
      shift_i_nxt = acc_next_i >> LANE_W;
      shift_q_nxt = acc_next_q >> LANE_W;
      beat_nxt    = BEAT_W'(1);
    end else begin
      case (state)
        ST_IDLE: begin
          busy_nxt = 1'b0;
        end
        ST_SHIFT: begin
          if (beat == BEAT_LAST) begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
            beat_nxt  = '0;
          end else begin
            ro_i_nxt    = shift_i[LANE_W-1:0];
            ro_q_nxt    = shift_q[LANE_W-1:0];
            shift_i_nxt = shift_i >> LANE_W;
            shift_q_nxt = shift_q >> LANE_W;
            beat_nxt    = beat + BEAT_W'(1);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          busy_nxt  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unison_array_readout.sv
// Bench for unison_array_readout: two instances (FRAME_LEN 16 and 2) against a frame-level reference model.
module tb_unison_array_readout;

  localparam int NC   = 2;
  localparam int W    = 4;
  localparam int NB   = NC * W / 2;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));
  localparam int MODV = 1 << W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstb;
  logic          ud_en;
  logic [NC-1:0] comp_i, comp_q, lo_i, lo_q;
  logic [1:0]    roi [2];
  logic [1:0]    roq [2];
  logic          fs  [2];
  logic          bs  [2];
  logic          ov  [2];

  unison_array_readout #(.NUM_CH(NC), .CNT_W(W), .FRAME_LEN(16)) u_dut (
    .clk_master (clk), .rstb (rstb), .ud_en (ud_en),
    .comp_high_I (comp_i), .comp_high_Q (comp_q), .lo_I (lo_i), .lo_Q (lo_q),
    .read_out_I (roi[0]), .read_out_Q (roq[0]),
    .frame_sync (fs[0]), .busy (bs[0]), .overrun (ov[0])
  );

  unison_array_readout #(.NUM_CH(NC), .CNT_W(W), .FRAME_LEN(2)) u_dut_ovr (
    .clk_master (clk), .rstb (rstb), .ud_en (ud_en),
    .comp_high_I (comp_i), .comp_high_Q (comp_q), .lo_I (lo_i), .lo_Q (lo_q),
    .read_out_I (roi[1]), .read_out_Q (roq[1]),
    .frame_sync (fs[1]), .busy (bs[1]), .overrun (ov[1])
  );

  int fl [2] = '{16, 2};

  // Reference: integer accumulators per frame, snapshot expanded into a beat list.
  int acc    [2][NC][2];
  int fc     [2];
  bit m_busy [2];
  int m_ptr  [2];
  bit m_sync [2];
  bit m_ovr  [2];
  int bi     [2][NB];
  int bq     [2][NB];

  int compares = 0;
  int errs     = 0;

  function automatic int limit(input int v);
`ifdef UNISON_SAT_EN
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
`else
    if (v > MAXV) return v - MODV;
    if (v < MINV) return v + MODV;
`endif
    return v;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compares++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NC; c++) begin
        acc[d][c][0] = 0;
        acc[d][c][1] = 0;
      end
      fc[d] = 0; m_busy[d] = 0; m_ptr[d] = 0; m_sync[d] = 0; m_ovr[d] = 0;
    end
  endtask

  task automatic model_clock();
    for (int d = 0; d < 2; d++) begin
      bit snap;
      snap = ud_en && (fc[d] == fl[d] - 1);
      if (ud_en) begin
        for (int c = 0; c < NC; c++) begin
          if (comp_i[c]) acc[d][c][0] = limit(acc[d][c][0] + (lo_i[c] ? 1 : -1));
          if (comp_q[c]) acc[d][c][1] = limit(acc[d][c][1] + (lo_q[c] ? 1 : -1));
        end
      end
      if (snap) begin
        if (m_busy[d]) m_ovr[d] = 1;
        for (int k = 0; k < NB; k++) begin
          int c, pos;
          c   = (2 * k) / W;
          pos = (2 * k) % W;
          bi[d][k] = ((acc[d][c][0] & (MODV - 1)) >> pos) & 3;
          bq[d][k] = ((acc[d][c][1] & (MODV - 1)) >> pos) & 3;
        end
        for (int c = 0; c < NC; c++) begin
          acc[d][c][0] = 0;
          acc[d][c][1] = 0;
        end
        m_busy[d] = 1; m_ptr[d] = 0; m_sync[d] = 1;
      end else begin
        m_sync[d] = 0;
        if (m_busy[d]) begin
          m_ptr[d]++;
          if (m_ptr[d] == NB) begin
            m_busy[d] = 0;
            m_ptr[d]  = 0;
          end
        end
      end
      if (ud_en) fc[d] = snap ? 0 : fc[d] + 1;
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_read_out_I", d), 8'(roi[d]), 8'(m_busy[d] ? bi[d][m_ptr[d]] : 0));
      chk($sformatf("d%0d_read_out_Q", d), 8'(roq[d]), 8'(m_busy[d] ? bq[d][m_ptr[d]] : 0));
      chk($sformatf("d%0d_frame_sync", d), 8'(fs[d]), 8'(m_sync[d]));
      chk($sformatf("d%0d_busy", d), 8'(bs[d]), 8'(m_busy[d]));
      chk($sformatf("d%0d_overrun", d), 8'(ov[d]), 8'(m_ovr[d]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    comp_i = '0; comp_q = '0; lo_i = '0; lo_q = '0;
  endtask

  initial begin
    rstb = 1'b0; ud_en = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    check_all();
    chk("reset_busy", 8'(bs[0]), 8'd0);
    rstb = 1'b1;
    ud_en = 1'b1;

    // 5 up and 2 down events on ch0 I: net +3 -> beats 11, 00.
    for (int c = 0; c < 16; c++) begin
      comp_i = (c < 7) ? 2'b01 : 2'b00;
      lo_i   = (c < 5) ? 2'b01 : 2'b00;
      step();
    end
    idle_inputs();
    chk("net3_beat0", 8'(roi[0]), 8'h3);
    chk("net3_sync0", 8'(fs[0]), 8'd1);
    step();
    chk("net3_beat1", 8'(roi[0]), 8'h0);
    chk("net3_sync1", 8'(fs[0]), 8'd0);
    step(); step();
    chk("net3_busy_beat3", 8'(bs[0]), 8'd1);
    step();
    chk("net3_busy_done", 8'(bs[0]), 8'd0);

    // 10 up events on ch1 Q within the rest of this frame.
    for (int c = 0; c < 12; c++) begin
      comp_q = (c < 10) ? 2'b10 : 2'b00;
      lo_q   = 2'b10;
      step();
    end
    idle_inputs();
    step(); step();
`ifdef UNISON_SAT_EN
    chk("q10_beat2", 8'(roq[0]), 8'h3);
    step();
    chk("q10_beat3", 8'(roq[0]), 8'h1);
`else
    chk("q10_beat2", 8'(roq[0]), 8'h2);
    step();
    chk("q10_beat3", 8'(roq[0]), 8'h2);
`endif

    // Five-cycle enable gap with ignored events pushes the snapshot out by five cycles.
    for (int c = 0; c < 18; c++) begin
      ud_en  = !(c >= 5 && c < 10);
      comp_i = (c < 5) ? 2'b10 : ((c < 10) ? 2'b11 : 2'b00);
      lo_i   = (c < 5) ? 2'b10 : 2'b00;
      step();
      if (c == 12) chk("gap_no_early_sync", 8'(fs[0]), 8'd0);
    end
    idle_inputs();
    chk("gap_sync", 8'(fs[0]), 8'd1);
    step(); step();
    chk("gap_ch1_beat2", 8'(roi[0]), 8'h1);

    // Event on the snapshot cycle itself lands in the shadow; next frame starts empty.
    for (int c = 0; c < 13; c++) step();
    comp_i = 2'b01; lo_i = 2'b01;
    step();
    idle_inputs();
    chk("snapcyc_beat0", 8'(roi[0]), 8'h1);
    for (int c = 0; c < 16; c++) step();
    chk("next_frame_zero", 8'(roi[0]), 8'h0);
    chk("next_frame_sync", 8'(fs[0]), 8'd1);

    chk("ovr_fast_set", 8'(ov[1]), 8'd1);
    chk("ovr_slow_clear", 8'(ov[0]), 8'd0);

    // Load nonzero data, then reset asynchronously while beat 2 is on the lanes.
    for (int c = 0; c < 16; c++) begin
      comp_q = (c < 3) ? 2'b01 : 2'b00;
      lo_q   = 2'b01;
      step();
    end
    idle_inputs();
    step(); step();
    #2 rstb = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_async_busy", 8'(bs[0]), 8'd0);
    chk("rst_ovr_cleared", 8'(ov[1]), 8'd0);
    #1 rstb = 1'b1;

    for (int c = 0; c < 16; c++) begin
      comp_i = (c < 2) ? 2'b01 : 2'b00;
      lo_i   = 2'b01;
      step();
    end
    idle_inputs();
    chk("post_rst_beat0", 8'(roi[0]), 8'h2);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 500; c++) begin
      ud_en  = ($urandom_range(0, 7) != 0);
      comp_i = NC'($urandom);
      comp_q = NC'($urandom);
      lo_i   = NC'($urandom);
      lo_q   = ($urandom_range(0, 3) != 0) ? 2'b11 : NC'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errs);
    $finish;
  end

endmodule

// File: doc/unison_array_readout.md
UNISON_ARRAY_READOUT -- requirements
Module: unison_array_readout

Interface
REQ-001 SHALL have parameter NUM_CH, default 6, number of I/Q channel pairs (1..16).
REQ-002 SHALL have parameter CNT_W, default 8, signed accumulator width per channel (even, 4..16).
REQ-003 SHALL have parameter FRAME_LEN, default 256, accumulation frame length in clk_master cycles (>=2).
REQ-004 SHALL have clk_master  in  1  sole clock; one clock; all state on rising edge.
REQ-005 SHALL have rstb  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ud_en  in  1  accumulation/frame-count enable.
REQ-007 SHALL have comp_high_I, comp_high_Q  in  NUM_CH each  per-channel comparator event strobes, one event per high cycle.
REQ-008 SHALL have lo_I, lo_Q  in  NUM_CH each  per-channel LO polarity: 1 = count up, 0 = count down.
REQ-009 SHALL have read_out_I, read_out_Q  out  2 each  serial readout lanes, 2 bits per beat.
REQ-010 SHALL have frame_sync  out  1  one-cycle pulse on the first beat of each readout frame.
REQ-011 SHALL have busy  out  1  high while serializer is in SHIFT.
REQ-012 SHALL have overrun  out  1  sticky flag: snapshot arrived while busy.

Function
REQ-013 SHALL keep per channel, per I and Q, a signed CNT_W accumulator: +1 when ud_en & comp_high & lo, -1 when ud_en & comp_high & ~lo, hold otherwise.
REQ-014 SHALL run a frame counter 0..FRAME_LEN-1 that advances only when ud_en=1 and wraps to 0.
REQ-015 SHALL, on the cycle the frame counter equals FRAME_LEN-1 with ud_en=1, load shadow registers with the accumulator value including that cycle's event, and clear all accumulators to 0.
REQ-016 SHALL implement serializer FSM states IDLE and SHIFT; IDLE->SHIFT on snapshot; SHIFT->IDLE after the last beat.
REQ-017 SHALL emit NUM_CH*CNT_W/2 beats per frame: channel 0 first, LSB first, I shadow on read_out_I and Q shadow on read_out_Q in the same beat.
REQ-018 SHALL present the first beat one cycle after the snapshot cycle, with frame_sync high in that cycle only.
REQ-019 SHALL drive read_out_I/Q to 2'b00 while in IDLE.
REQ-020 SHALL, on a snapshot while in SHIFT, set overrun, reload shadows, and restart at beat 0 with frame_sync.
REQ-021 SHALL keep the serializer running when ud_en=0; only accumulation and frame counting freeze.

Reset
REQ-022 SHALL, on rstb low at any time including mid-shift, clear accumulators, shadows, frame counter, FSM (IDLE), read_out_I/Q, frame_sync, busy and overrun to 0.
REQ-023 SHALL clear overrun by reset only.

Configuration
REQ-024 SHALL, with UNISON_SAT_EN defined, saturate accumulators at +(2^(CNT_W-1)-1) and -2^(CNT_W-1).
REQ-025 SHALL, with UNISON_SAT_EN undefined, wrap accumulators modulo 2^CNT_W.

Structure
REQ-026 SHALL place the FSM state encoding (IDLE, SHIFT) and the lane width constant (2) in shared package unison_pkg.
REQ-027 SHALL implement one accumulator, including the saturation option, as sub-module unison_updown_counter, instantiated 2*NUM_CH times.

Verification (NUM_CH=2, CNT_W=4, FRAME_LEN=16, 4 beats/frame)
REQ-028 SHALL check: ch0 5 I events with lo_I=1 and 2 with lo_I=0 in frame -> ch0 I beats 2'b11 then 2'b00, frame_sync on beat 0, busy high 4 cycles.
REQ-029 SHALL check: 10 up events on ch1 Q -> beats 2/3 on read_out_Q = 0111 with UNISON_SAT_EN defined, and 1010 without it.
REQ-030 SHALL check: ud_en low for 5 cycles mid-frame -> snapshot occurs 5 cycles later, and events during the gap are not counted.
REQ-031 SHALL check: FRAME_LEN=2 -> snapshot during SHIFT sets overrun=1, restarts at beat 0, and overrun persists until rstb.
REQ-032 SHALL check: rstb asserted at beat 2 -> all outputs 0 asynchronously, and the next frame's data starts from cleared accumulators.
REQ-033 SHALL check: an event on the snapshot cycle is included in the shadow, and the accumulator for the next frame starts at 0.
